// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: one ready-handshaked data-memory transaction per load/store,
// byte-lane enables, load extension, timeout trap. Optional misaligned trap via MEM_MISALIGN_TRAP_EN.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [5:0]  ex_opcode,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    output logic        stall,
    output logic        mem_req,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc,
    output logic [1:0]  exc_code
);
    localparam logic [5:0] OP_SB  = 6'b001111;
    localparam logic [5:0] OP_SH  = 6'b010000;
    localparam logic [5:0] OP_SW  = 6'b010001;
    localparam logic [5:0] OP_LB  = 6'b010010;
    localparam logic [5:0] OP_LBU = 6'b010011;
    localparam logic [5:0] OP_LH  = 6'b010100;
    localparam logic [5:0] OP_LHU = 6'b010101;
    localparam logic [5:0] OP_LW  = 6'b010110;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t      r_state, w_next;
    logic [5:0]  r_op;
    logic [1:0]  r_alo;
    logic [4:0]  r_rd;
    logic [7:0]  r_cnt;
    logic [3:0]  r_we;
    logic [31:0] r_addr, r_wdata;
    logic        r_wb_valid, r_exc;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic [1:0]  r_exc_code;

    logic        w_mem_op, w_trap, w_start, w_trap_evt, w_timeout_hit, w_done, w_r_load;
    logic [3:0]  w_we;
    logic [31:0] w_wdata, w_ld_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_mem_op = (ex_opcode >= OP_SB) && (ex_opcode <= OP_LW);

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = (((ex_opcode == OP_SH) || (ex_opcode == OP_LH) || (ex_opcode == OP_LHU)) && ex_addr[0])
                     || (((ex_opcode == OP_SW) || (ex_opcode == OP_LW)) && (ex_addr[1:0] != 2'b00));
    assign w_trap = w_misalign;
`else
    assign w_trap = 1'b0;
`endif

    assign w_start       = (r_state == S_IDLE) && ex_valid && w_mem_op && !w_trap;
    assign w_trap_evt    = (r_state == S_IDLE) && ex_valid && w_mem_op && w_trap;
    assign w_timeout_hit = (r_state == S_ACCESS) && !mem_ready && (r_cnt == TO_LAST);
    assign w_done        = (r_state == S_ACCESS) && mem_ready;
    assign w_r_load      = (r_op >= OP_LB);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next = S_ACCESS;
            S_ACCESS: if (w_done || w_timeout_hit) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs; stall is held low while reset is asserted even if ex_valid is high
    always_comb begin
        mem_req = (r_state == S_ACCESS);
        stall   = rst_n && (((r_state == S_IDLE) && ex_valid && w_mem_op && !w_trap)
                         || ((r_state == S_ACCESS) && !mem_ready && !w_timeout_hit));
    end

    // Store lane enables and replicated data; misaligned halves/words fall back to natural alignment
    always_comb begin
        w_we    = 4'b0000;
        w_wdata = 32'h0;
        case (ex_opcode)
            OP_SB: begin
                w_we    = 4'b0001 << ex_addr[1:0];
                w_wdata = {4{ex_wdata[7:0]}};
            end
            OP_SH: begin
                w_we    = ex_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{ex_wdata[15:0]}};
            end
            OP_SW: begin
                w_we    = 4'b1111;
                w_wdata = ex_wdata;
            end
            default: ;
        endcase
    end

    assign w_byte = mem_rdata[8*r_alo +: 8];
    assign w_half = r_alo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        w_ld_data = mem_rdata;
        case (r_op)
            OP_LB:   w_ld_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_ld_data = {24'h0, w_byte};
            OP_LH:   w_ld_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_ld_data = {16'h0, w_half};
            default: w_ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= 6'h0;
            r_alo   <= 2'b00;
            r_rd    <= 5'h0;
            r_cnt   <= 8'h0;
            r_we    <= 4'b0000;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
        end else if (w_start) begin
            r_op    <= ex_opcode;
            r_alo   <= ex_addr[1:0];
            r_rd    <= ex_rd;
            r_cnt   <= 8'h0;
            r_we    <= w_we;
            r_addr  <= {ex_addr[31:2], 2'b00};
            r_wdata <= w_wdata;
        end else if (w_done || w_timeout_hit) begin
            r_we    <= 4'b0000;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
        end else if (r_state == S_ACCESS) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= 5'h0;
            r_wb_data  <= 32'h0;
            r_exc      <= 1'b0;
            r_exc_code <= 2'b00;
        end else begin
            r_wb_valid <= w_done && w_r_load;
            if (w_done && w_r_load) begin
                r_wb_rd   <= r_rd;
                r_wb_data <= w_ld_data;
            end
            r_exc      <= w_timeout_hit || w_trap_evt;
            r_exc_code <= w_timeout_hit ? 2'b10 : (w_trap_evt ? 2'b01 : 2'b00);
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign wb_valid  = r_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign exc       = r_exc;
    assign exc_code  = r_exc_code;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a cycle timeline is planned from per-op rules (wait counts, lane math),
// then replayed into the DUT and compared each cycle; literal pins check the directed cases.
module tb_mem_access_ctrl;
    localparam int TO = 15;
    localparam int N  = 6000;
    localparam logic [5:0] SB = 6'h0F, SH = 6'h10, SW = 6'h11, LB = 6'h12,
                           LBU = 6'h13, LH = 6'h14, LHU = 6'h15, LW = 6'h16;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        ex_valid = 1'b0, mem_ready = 1'b0;
    logic [5:0]  ex_opcode = 6'h0;
    logic [31:0] ex_addr = 32'h0, ex_wdata = 32'h0, mem_rdata = 32'h0;
    logic [4:0]  ex_rd = 5'h0;
    logic        stall, mem_req, wb_valid, exc;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata, wb_data;
    logic [4:0]  wb_rd;
    logic [1:0]  exc_code;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_addr(ex_addr),
        .ex_wdata(ex_wdata), .ex_rd(ex_rd), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .exc(exc), .exc_code(exc_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ev; logic [5:0] op; logic [31:0] a, wd; logic [4:0] rd; logic rdy; logic [31:0] rdat;
    } drv_t;
    typedef struct {
        logic stall, req, ld; logic [3:0] we; logic [31:0] ma, mwd;
        logic wbv; logic [4:0] wbrd; logic [31:0] wbd; logic exc; logic [1:0] ec;
    } exp_t;

    drv_t d[N];
    exp_t e[N];
    logic [3:0]  a_we[N];
    logic [31:0] a_ma[N], a_mwd[N], a_wbd[N];
    logic [4:0]  a_wbrd[N];
    logic        a_req[N], a_exc[N];
    logic [1:0]  a_ec[N];

    int n = 0, cur = 0, errs = 0, checks = 0, g_t0 = 0, g_end = 0;
    bit run = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cur, act, exp);
        end
    endtask

    function automatic bit is_mem(input logic [5:0] op); return op >= SB && op <= LW; endfunction
    function automatic bit is_load(input logic [5:0] op); return op >= LB && op <= LW; endfunction

    function automatic bit misal(input logic [5:0] op, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
        return ((op == SH || op == LH || op == LHU) && (a % 2 != 0)) || ((op == SW || op == LW) && (a % 4 != 0));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] f_we(input logic [5:0] op, input logic [31:0] a);
        if (op == SB) return 4'(1 << (a % 4));
        if (op == SH) return ((a / 2) % 2 != 0) ? 4'hC : 4'h3;
        if (op == SW) return 4'hF;
        return 4'h0;
    endfunction

    function automatic logic [31:0] f_wd(input logic [5:0] op, input logic [31:0] wd);
        if (op == SB) return (wd % 256) * 32'h01010101;
        if (op == SH) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] f_ld(input logic [5:0] op, input logic [31:0] a, input logic [31:0] r);
        logic [31:0] b, h;
        b = (r >> (8 * (a % 4))) % 256;
        h = (r >> (16 * ((a / 2) % 2))) % 65536;
        case (op)
            LB:  return (b >= 128) ? b + 32'hFFFFFF00 : b;
            LBU: return b;
            LH:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
            LHU: return h;
            default: return r;
        endcase
    endfunction

    function automatic logic [5:0] rnd_nonmem();
        logic [5:0] o;
        o = 6'($urandom);
        while (is_mem(o)) o = 6'($urandom);
        return o;
    endfunction

    task automatic put(input logic ev, input logic [5:0] op);
        d[n] = '{ev, op, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom};
    endtask

    // Append one op (after `gap` idle/non-memory cycles) to the planned timeline.
    task automatic add_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] rd, input int waits, input logic [31:0] rdat, input int gap);
        int acc;
        for (int g = 0; g < gap; g++) begin
            put(1'($urandom), rnd_nonmem()); n++;
        end
        g_t0 = n;
        put(1'b1, op); d[n].a = a; d[n].wd = wd; d[n].rd = rd;
        if (misal(op, a)) begin
            e[n].stall = 1'b0; n++;
            e[n].exc = 1'b1; e[n].ec = 2'b01;
            g_end = n;
            return;
        end
        e[n].stall = 1'b1; n++;
        acc = (waits >= TO) ? TO : waits + 1;
        for (int k = 0; k < acc; k++) begin
            put(1'($urandom), 6'($urandom));
            d[n].rdy = (k == acc - 1) && (waits < TO);
            d[n].rdat = rdat;
            e[n].req = 1'b1; e[n].ld = is_load(op);
            e[n].we = f_we(op, a); e[n].ma = a - (a % 4); e[n].mwd = f_wd(op, wd);
            e[n].stall = (k < acc - 1);
            n++;
        end
        g_end = n;
        if (waits >= TO) begin
            e[n].exc = 1'b1; e[n].ec = 2'b10;
        end else if (is_load(op)) begin
            e[n].wbv = 1'b1; e[n].wbrd = rd; e[n].wbd = f_ld(op, a, rdat);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            a_we[cur] = mem_we; a_ma[cur] = mem_addr; a_mwd[cur] = mem_wdata; a_wbd[cur] = wb_data;
            a_wbrd[cur] = wb_rd; a_req[cur] = mem_req; a_exc[cur] = exc; a_ec[cur] = exc_code;
            chk("stall", 32'(stall), 32'(e[cur].stall));
            chk("mem_req", 32'(mem_req), 32'(e[cur].req));
            if (e[cur].req) begin
                chk("mem_we", 32'(mem_we), 32'(e[cur].we));
                chk("mem_addr", mem_addr, e[cur].ma);
                if (!e[cur].ld) chk("mem_wdata", mem_wdata, e[cur].mwd);
            end
            chk("wb_valid", 32'(wb_valid), 32'(e[cur].wbv));
            if (e[cur].wbv) begin
                chk("wb_rd", 32'(wb_rd), 32'(e[cur].wbrd));
                chk("wb_data", wb_data, e[cur].wbd);
            end
            chk("exc", 32'(exc), 32'(e[cur].exc));
            if (e[cur].exc) chk("exc_code", 32'(exc_code), 32'(e[cur].ec));
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 0);      chk({tag, "_req"}, 32'(mem_req), 0);
        chk({tag, "_we"}, 32'(mem_we), 0);        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);       chk({tag, "_wbv"}, 32'(wb_valid), 0);
        chk({tag, "_wbrd"}, 32'(wb_rd), 0);       chk({tag, "_wbd"}, wb_data, 0);
        chk({tag, "_exc"}, 32'(exc), 0);          chk({tag, "_ec"}, 32'(exc_code), 0);
    endtask

    initial begin
        int i_sb, i_lb, i_lbu, i_lh, i_lhu, i_to, i_sh, reqs;
        logic [5:0] op;
        for (int i = 0; i < N; i++) e[i] = '{default: '0};

        // Reset state, with a store presented and a stray ready
        ex_valid = 1'b1; ex_opcode = SW; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); cur = 0; chk_zero("rst");
        @(posedge clk); #1 rst_n = 1'b1; ex_valid = 1'b0; mem_ready = 1'b0;

        // Directed ops
        add_op(SB, 32'h1003, 32'h000000A5, 5'd1, 0, 32'h0, 1);           i_sb  = g_t0 + 1;
        add_op(LB, 32'h2001, 32'h0, 5'd7, 3, 32'h00008000, 0);
        add_op(LB, 32'h2001, 32'h0, 5'd9, 3, 32'h0000F000, 0);           i_lb  = g_end;
        add_op(LBU, 32'h2001, 32'h0, 5'd10, 3, 32'h0000F000, 0);         i_lbu = g_end;
        add_op(LH, 32'h2002, 32'h0, 5'd11, 0, 32'h80010000, 0);          i_lh  = g_end;
        add_op(LHU, 32'h2002, 32'h0, 5'd12, 1, 32'h80010000, 0);         i_lhu = g_end;
        add_op(SW, 32'h4000, 32'hDEADBEEF, 5'd0, 100, 32'h0, 1);         i_to  = g_t0;
        add_op(LW, 32'h5004, 32'h0, 5'd13, TO - 1, 32'hCAFEF00D, 0);
        add_op(SH, 32'h3001, 32'h00001234, 5'd0, 0, 32'h0, 0);           i_sh  = g_t0;
        add_op(SW, 32'h6002, 32'h11223344, 5'd0, 0, 32'h0, 0);
        // Random ops
        for (int k = 0; k < 60; k++) begin
            op = SB + 6'($urandom_range(0, 7));
            add_op(op, $urandom, $urandom, 5'($urandom), ($urandom_range(0, 9) == 0) ? TO + 2 : $urandom_range(0, 4),
                   $urandom, $urandom_range(0, 2));
        end
        add_op(LB, 32'h7000, 32'h0, 5'd3, 0, 32'h0000007F, 0);
        for (int g = 0; g < 3; g++) begin put(1'b0, 6'h0); n++; end

        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cur = i;
            ex_valid = d[i].ev; ex_opcode = d[i].op; ex_addr = d[i].a; ex_wdata = d[i].wd;
            ex_rd = d[i].rd; mem_ready = d[i].rdy; mem_rdata = d[i].rdat;
            run = 1'b1;
        end
        @(posedge clk); #1 run = 1'b0; ex_valid = 1'b0; mem_ready = 1'b0;

        // Literal pins for the directed cases
        cur = i_sb;  chk("sb_we", 32'(a_we[i_sb]), 32'h8); chk("sb_addr", a_ma[i_sb], 32'h1000);
        chk("sb_wdata", a_mwd[i_sb], 32'hA5A5A5A5);
        cur = i_lb;  chk("lb_data", a_wbd[i_lb], 32'hFFFFFFF0); chk("lb_rd", 32'(a_wbrd[i_lb]), 32'd9);
        cur = i_lbu; chk("lbu_data", a_wbd[i_lbu], 32'h000000F0);
        cur = i_lh;  chk("lh_data", a_wbd[i_lh], 32'hFFFF8001);
        cur = i_lhu; chk("lhu_data", a_wbd[i_lhu], 32'h00008001);
        reqs = 0;
        for (int i = i_to; i <= i_to + TO + 1; i++) reqs += int'(a_req[i]);
        cur = i_to;  chk("to_req_cycles", reqs, TO);
        chk("to_exc", 32'(a_exc[i_to + TO + 1]), 1); chk("to_code", 32'(a_ec[i_to + TO + 1]), 2);
        cur = i_sh;
`ifdef MEM_MISALIGN_TRAP_EN
        chk("sh_noreq", 32'(a_req[i_sh + 1]), 0); chk("sh_exc", 32'(a_exc[i_sh + 1]), 1);
        chk("sh_code", 32'(a_ec[i_sh + 1]), 1);
`else
        chk("sh_we", 32'(a_we[i_sh + 1]), 32'h3); chk("sh_addr", a_ma[i_sh + 1], 32'h3000);
`endif

        // Reset in the middle of a pending store
        @(posedge clk); #1 ex_valid = 1'b1; ex_opcode = SW; ex_addr = 32'h44; ex_wdata = 32'h55; mem_ready = 1'b0;
        @(posedge clk); #1 ex_valid = 1'b0;
        @(negedge clk); chk("mid_req_before", 32'(mem_req), 1);
        #2 rst_n = 1'b0;
        #1 chk_zero("midrst");
        mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_wbv", 32'(wb_valid), 0); chk("post_req", 32'(mem_req), 0); chk("post_exc", 32'(exc), 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller for the five-stage pipeline. Takes the EX/MEM operation (opcode, ALU-computed address, store data, destination register) and sequences one data-memory transaction per load/store over a ready-based handshake. Generates byte-lane write enables, extracts and extends load data, and stalls upstream stages until the memory completes. Also traps on timeout and, optionally, on misaligned addresses.

## Interface
Parameters:
- TIMEOUT, 15: max ACCESS cycles without `mem_ready` before abort (1..255).

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX/MEM slot holds a valid instruction
- ex_opcode  in  6  operation: SB=6'b001111, SH=6'b010000, SW=6'b010001, LB=6'b010010, LBU=6'b010011, LH=6'b010100, LHU=6'b010101, LW=6'b010110; others are non-memory
- ex_addr  in  32  byte address (ALU result)
- ex_wdata  in  32  store data (rv2)
- ex_rd  in  5  load destination register
- stall  out  1  hold EX/MEM and earlier stages (combinational)
- mem_req  out  1  memory request
- mem_we  out  4  byte-lane write enables; 0 for loads
- mem_addr  out  32  word address (bits[1:0]=0)
- mem_wdata  out  32  lane-replicated store data
- mem_ready  in  1  memory completes the request this cycle
- mem_rdata  in  32  read word, valid with `mem_ready`
- wb_valid  out  1  one-cycle pulse: load result valid
- wb_rd  out  5  load destination
- wb_data  out  32  extended load data
- exc  out  1  one-cycle exception pulse
- exc_code  out  2  01 misaligned, 10 timeout

## Operation
- States: IDLE, ACCESS.
- IDLE: memory op with ex_valid -> latch opcode/addr/data/rd, drive mem_* from latched values next cycle, go ACCESS. Non-memory ops: no action, stall=0.
- stall = (IDLE & ex_valid & mem_op & !trap) | (ACCESS & !mem_ready & !timeout_hit). Forced 0 in reset.
- ACCESS: mem_req=1, outputs stable until completion. mem_ready=1 -> IDLE; loads pulse wb_valid next cycle.
- Little-endian lanes. SB: we=0001<<addr[1:0], wdata={4{b}}. SH: we=0011 (addr[1]=0) or 1100, wdata={2{h}}. SW: we=1111.
- Loads: byte = mem_rdata lane addr[1:0], half = lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
- Timeout: 8-bit counter cleared on ACCESS entry, increments each ACCESS cycle without mem_ready; reaching TIMEOUT -> mem_req drops, exc pulse code 10, IDLE, no wb_valid, stall=0 that cycle (instruction retires squashed).
- mem_ready outside ACCESS is ignored.

## Timing
- Reset (async, immediate): IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, wb_valid=0, wb_rd=0, wb_data=0, exc=0, exc_code=0, counter=0. Outstanding response after reset is ignored.
- Minimum latency: 2 cycles per memory op (IDLE detect cycle + one ACCESS cycle with mem_ready=1); each extra wait cycle adds 1.
- wb_valid/wb_data/wb_rd registered, 1 cycle after the mem_ready edge; exc registered, 1 cycle after the event.
- Back-to-back ops: next op seen in IDLE the cycle after completion; no bubble beyond the detect cycle.
- ex_valid deasserted while in ACCESS has no effect (latched copy used).

## Configuration
- MEM_MISALIGN_TRAP_EN defined: SH with addr[0]=1, LH/LHU with addr[0]=1, SW/LW with addr[1:0]!=0 issue no request; exc pulse code 01 next cycle; stall=0; no wb_valid.
- Undefined: misaligned addresses are truncated to natural alignment (half: bit0 cleared, word: bits1:0 cleared) and the access proceeds normally; exc code 01 never raised.

## Test plan
- Reset mid-ACCESS (SW pending, mem_ready=0) -> mem_req=0 immediately, all outputs 0; later mem_ready ignored, no wb_valid.
- SB addr=0x1003 wdata=0x000000A5, mem_ready first ACCESS cycle -> mem_we=1000, mem_addr=0x1000, mem_wdata=0xA5A5A5A5, stall high exactly 1 cycle.
- LB addr=0x2001, mem_rdata=0x00008000 vs 0x0000F000 after 3 wait cycles -> wb_data=0xFFFFFFF0 for F0; LBU -> 0x000000F0; wb_rd echoes ex_rd, stall high 4 cycles.
- LH addr=0x2002, mem_rdata=0x8001_0000 -> wb_data=0xFFFF8001; LHU -> 0x00008001.
- SW with mem_ready held 0, TIMEOUT=15 -> mem_req high 15 cycles, then exc=1 code 10, no write completes, stall released.
- SH addr=0x3001: with MEM_MISALIGN_TRAP_EN -> no mem_req, exc code 01; without -> mem_we=0011, mem_addr=0x3000.
